game_stage_ctrl: RTL
====================

Name: game_stage_ctrl

Overview:
Top-level game-flow controller for the two-player fighter. It tracks both players' hit points from projectile-hit pulses and sequences START -> BATTLE -> WIN/LOSE -> START on keyboard input. It drives the one-hot stage flags and HP values consumed directly downstream by color_mapper (start_l, battle_l, win_l, lose_l) and the HUD.

Parameters:
HP_MAX, 8'd100, hit points loaded into each player at START -> BATTLE and on reset
DAMAGE, 8'd10, HP removed per accepted hit
END_FRAMES, 8'd120, minimum frames spent in WIN/LOSE before Enter is honoured
KEY_ENTER, 8'h28, USB HID keycode that advances the stage

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  VGA vertical sync; its rising edge marks one frame
keycode  in  8  current USB keycode; 8'h00 means no key
hit_p1  in  1  one-Clk pulse: projectile struck player 1
hit_p2  in  1  one-Clk pulse: projectile struck player 2
start_l  out  1  stage flag: title screen
battle_l  out  1  stage flag: fight in progress
win_l  out  1  stage flag: player 1 won
lose_l  out  1  stage flag: player 1 lost
hp1  out  8  player 1 HP
hp2  out  8  player 2 HP

Behaviour:
- All state is updated on posedge Clk. Reset is sampled synchronously; Reset has priority over every other input.
- Reset values: start_l=1, battle_l=0, win_l=0, lose_l=0, hp1=hp2=HP_MAX, frame counter=0. Reset in any state, including mid-battle, returns to these values on the next edge.
- Stage flags are registered and decoded from the state register. Exactly one flag is high in every cycle.
- Frame tick: register frame_clk once. tick = frame_clk & ~frame_clk_q, a one-Clk pulse on each rising edge.
- Enter press: enter_now = (keycode == KEY_ENTER). Register enter_now each cycle. press = enter_now & ~enter_q. Holding the key produces exactly one press.
- States are START, BATTLE, WIN, LOSE.
- START:
  - hp1 and hp2 are held at HP_MAX.
  - On press: go to BATTLE. The flags change on the same edge that registers the press, so they are visible one cycle after the key first appears.
- BATTLE:
  - hit_p1 accepted: hp1 <= (hp1 > DAMAGE) ? hp1 - DAMAGE : 0. HP saturates at 0 and never wraps.
  - hit_p2 accepted: same rule applied to hp2.
  - Simultaneous hit_p1 and hit_p2 pulses both apply in the same cycle.
  - The end-of-fight check uses the next-state HP values, so the transition happens on the same edge as the fatal hit.
  - If next hp1 == 0: go to LOSE. This holds even if next hp2 == 0 (a tie counts as a loss).
  - Else if next hp2 == 0: go to WIN.
  - Entering WIN/LOSE clears the frame counter.
  - Enter has no effect in BATTLE.
- WIN/LOSE:
  - hp1 and hp2 are frozen; hits are ignored.
  - The 8-bit frame counter increments on each tick and saturates at END_FRAMES.
  - A press while counter < END_FRAMES is discarded and is not remembered.
  - A press with counter == END_FRAMES: go to START, reload both HP values to HP_MAX, clear the counter.
- Hit pulses outside BATTLE are ignored.

Optional Feature:
INVULN_EN.
- Defined: each player has an 8-bit invulnerability counter.
  - An accepted hit loads that player's counter with INVULN_FRAMES (localparam 8'd30).
  - The counter decrements on each tick down to 0.
  - A hit arriving while the counter is nonzero is ignored.
  - Both counters clear on reset and on entering BATTLE.
- Undefined: the counters are not present, and every hit pulse in BATTLE applies DAMAGE.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic [1:0] stage_t {START, BATTLE, WIN, LOSE}
  - localparams KEY_ENTER, HP_MAX, DAMAGE
- One sub-module, rise_edge_det (Clk, Reset, d, pulse), is instantiated for both frame_clk and enter_now.

Test Plan:
- Reset asserted for 2 cycles during BATTLE with hp1=40 -> start_l=1, others 0, hp1=hp2=100 on the first edge after Reset.
- START; keycode 8'h28 held for 50 cycles -> exactly one transition to BATTLE one cycle after the key appears; no further change.
- BATTLE; 10 hit_p2 pulses -> hp2 steps 90..0, win_l=1 on the same edge as the 10th hit; an 11th pulse leaves hp2=0.
- BATTLE with hp1=hp2=10; hit_p1 and hit_p2 in the same cycle -> hp1=hp2=0, lose_l=1, win_l=0.
- WIN; Enter pressed at tick 60 -> stays WIN. Enter pressed again after 120 ticks -> start_l=1, hp1=hp2=100.
- INVULN_EN defined; two hit_p1 pulses 5 ticks apart -> hp1=90. Third pulse after 30 ticks -> hp1=80.

Source files
------------

// File: rtl/game_pkg.sv
// Shared stage encoding, game constants and the saturating damage helper
// used by the game-flow controller.
package game_pkg;

  typedef enum logic [1:0] {
    START  = 2'd0,
    BATTLE = 2'd1,
    WIN    = 2'd2,
    LOSE   = 2'd3
  } stage_t;

  localparam logic [7:0] KEY_ENTER     = 8'h28;
  localparam logic [7:0] HP_MAX        = 8'd100;
  localparam logic [7:0] DAMAGE        = 8'd10;
  localparam logic [7:0] END_FRAMES    = 8'd120;
  localparam logic [7:0] INVULN_FRAMES = 8'd30;

  // HP never wraps: a hit on a player at or below DAMAGE leaves exactly 0.
  function automatic logic [7:0] apply_hit(input logic [7:0] hp);
    return (hp > DAMAGE) ? (hp - DAMAGE) : 8'd0;
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: pulse is high for the one Clk cycle in which d is
// high and was low on the previous cycle.
module rise_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge Clk) begin
    if (Reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/game_stage_ctrl.sv
// Game-flow controller: START -> BATTLE -> WIN/LOSE -> START with per-player
// HP tracking. Define INVULN_EN to add per-player post-hit invulnerability.
module game_stage_ctrl
  import game_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic       start_l,
  output logic       battle_l,
  output logic       win_l,
  output logic       lose_l,
  output logic [7:0] hp1,
  output logic [7:0] hp2
);

  stage_t     state, state_n;
  logic [7:0] hp1_n, hp2_n;
  logic [7:0] frame_cnt, frame_cnt_n;
  logic       tick, press, enter_now;
  logic       acc1, acc2;

  assign enter_now = (keycode == KEY_ENTER);

  rise_edge_det u_frame_edge (.Clk(Clk), .Reset(Reset), .d(frame_clk), .pulse(tick));
  rise_edge_det u_enter_edge (.Clk(Clk), .Reset(Reset), .d(enter_now), .pulse(press));

`ifdef INVULN_EN
  logic [7:0] inv1, inv2, inv1_n, inv2_n;

  assign acc1 = hit_p1 & (inv1 == 8'd0);
  assign acc2 = hit_p2 & (inv2 == 8'd0);

  // An accepted hit reloads the window; entering BATTLE starts both clean.
  always_comb begin
    inv1_n = inv1;
    inv2_n = inv2;
    if (tick && inv1 != 8'd0) inv1_n = inv1 - 8'd1;
    if (tick && inv2 != 8'd0) inv2_n = inv2 - 8'd1;
    if (state == BATTLE && acc1) inv1_n = INVULN_FRAMES;
    if (state == BATTLE && acc2) inv2_n = INVULN_FRAMES;
    if (state == START && press) begin
      inv1_n = 8'd0;
      inv2_n = 8'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      inv1 <= 8'd0;
      inv2 <= 8'd0;
    end else begin
      inv1 <= inv1_n;
      inv2 <= inv2_n;
    end
  end
`else
  assign acc1 = hit_p1;
  assign acc2 = hit_p2;
`endif

  always_comb begin
    state_n     = state;
    hp1_n       = hp1;
    hp2_n       = hp2;
    frame_cnt_n = frame_cnt;
    case (state)
      START: begin
        hp1_n = HP_MAX;
        hp2_n = HP_MAX;
        if (press) state_n = BATTLE;
      end
      BATTLE: begin
        if (acc1) hp1_n = apply_hit(hp1);
        if (acc2) hp2_n = apply_hit(hp2);
        // Decided on next-state HP so the fatal hit and the stage change share an edge.
        if (hp1_n == 8'd0) begin
          state_n     = LOSE;
          frame_cnt_n = 8'd0;
        end else if (hp2_n == 8'd0) begin
          state_n     = WIN;
          frame_cnt_n = 8'd0;
        end
      end
      WIN, LOSE: begin
        if (press && frame_cnt == END_FRAMES) begin
          state_n     = START;
          hp1_n       = HP_MAX;
          hp2_n       = HP_MAX;
          frame_cnt_n = 8'd0;
        end else if (tick && frame_cnt < END_FRAMES) begin
          frame_cnt_n = frame_cnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= START;
      hp1       <= HP_MAX;
      hp2       <= HP_MAX;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_n;
      hp1       <= hp1_n;
      hp2       <= hp2_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  assign start_l  = (state == START);
  assign battle_l = (state == BATTLE);
  assign win_l    = (state == WIN);
  assign lose_l   = (state == LOSE);

endmodule
